rx_block_ctrl: RTL and testbench

Sequencing controller for the receive-side input shift register. It accepts 64-bit words from the upstream host interface and pulses that register's `shift_enable` once per accepted word. When a full 128-bit block has been assembled, it presents the block to the AES core with a valid/ready handshake. It also zero-pads a short final block and keeps a running count of the blocks it has delivered.

---
 rtl/rx_block_ctrl.sv | 117 +++++++++++
 tb/tb_rx_block_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_ctrl.sv
// Receive-side block sequencer: paces the input shift register one word at a time,
// zero-pads short final blocks and hands complete blocks to the AES core.
module rx_block_ctrl #(
    parameter int WORDS_PER_BLOCK = 2,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid,
    input  logic             word_last,
    output logic             word_ready,
    input  logic             abort,
    output logic             shift_enable,
    output logic             pad_sel,
    output logic             block_valid,
    output logic             block_last,
    input  logic             block_ready,
    output logic [CNT_W-1:0] block_count
);

    localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [CW-1:0]    LAST_IDX = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0]    WORD_ONE = CW'(1);
    localparam logic [CNT_W-1:0] BLK_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PAD  = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     word_cnt_r;
    logic              last_q_r;
    logic [CNT_W-1:0]  block_count_r;

    logic              word_ready_s;
    logic              accept_s;
    logic              handshake_s;

    // Upstream readiness: a full block frees its slot only when the core takes it.
    always_comb begin
        word_ready_s = 1'b0;
        case (state_r)
            S_IDLE, S_FILL: word_ready_s = 1'b1;
            S_FULL:         word_ready_s = block_ready;
            default:        word_ready_s = 1'b0;
        endcase
    end

    assign accept_s     = word_valid & word_ready_s & ~abort;
    assign handshake_s  = (state_r == S_FULL) & block_ready & ~abort;

    // The shift must be combinational so the register captures the word on this edge.
    assign word_ready   = word_ready_s;
    assign shift_enable = accept_s | ((state_r == S_PAD) & ~abort);
    assign pad_sel      = (state_r == S_PAD);
    assign block_valid  = (state_r == S_FULL);
    assign block_last   = (state_r == S_FULL) & last_q_r;
    assign block_count  = block_count_r;

    // Block sequencing FSM, word counter, last flag and delivered-block counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            word_cnt_r    <= '0;
            last_q_r      <= 1'b0;
            block_count_r <= '0;
        end else if (abort) begin
            state_r    <= S_IDLE;
            word_cnt_r <= '0;
            last_q_r   <= 1'b0;
        end else begin
            if (handshake_s) begin
                block_count_r <= block_count_r + BLK_ONE;
                last_q_r      <= 1'b0;
            end
            case (state_r)
                // FULL shares this path: an accepted word there is a pass-through.
                S_IDLE, S_FILL, S_FULL: begin
                    if (accept_s) begin
                        if (word_cnt_r == LAST_IDX) begin
                            state_r    <= S_FULL;
                            word_cnt_r <= '0;
                            last_q_r   <= word_last;
                        end else if (word_last) begin
                            state_r    <= S_PAD;
                            word_cnt_r <= word_cnt_r + WORD_ONE;
                            last_q_r   <= 1'b1;
                        end else begin
                            state_r    <= S_FILL;
                            word_cnt_r <= word_cnt_r + WORD_ONE;
                        end
                    end else if (handshake_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_PAD: begin
                    if (word_cnt_r == LAST_IDX) begin
                        state_r    <= S_FULL;
                        word_cnt_r <= '0;
                    end else begin
                        word_cnt_r <= word_cnt_r + WORD_ONE;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    word_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_block_ctrl.sv
// Table-driven bench for rx_block_ctrl with an external 128-bit shift register
// and a second narrow-counter instance for the wrap case.
module tb_rx_block_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        word_valid, word_last, abort, block_ready;
    logic        word_ready, shift_enable, pad_sel, block_valid, block_last;
    logic [15:0] block_count;
    logic [63:0] data_in;
    logic [127:0] data_out;

    logic       v4, br4;
    logic       l4, ab4;
    logic       wr4, se4, ps4, bv4, bl4;
    logic [3:0] cnt4;

    rx_block_ctrl #(.WORDS_PER_BLOCK(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word_last(word_last),
        .word_ready(word_ready), .abort(abort), .shift_enable(shift_enable),
        .pad_sel(pad_sel), .block_valid(block_valid), .block_last(block_last),
        .block_ready(block_ready), .block_count(block_count)
    );

    rx_block_ctrl #(.WORDS_PER_BLOCK(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .word_valid(v4), .word_last(l4),
        .word_ready(wr4), .abort(ab4), .shift_enable(se4),
        .pad_sel(ps4), .block_valid(bv4), .block_last(bl4),
        .block_ready(br4), .block_count(cnt4)
    );

    // The receive shift register that the controller drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_out <= 128'h0;
        else if (shift_enable) data_out <= {data_out[63:0], (pad_sel ? 64'h0 : data_in)};
    end

    localparam logic [63:0] A  = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] B  = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] C1 = 64'hC1C1_0000_0000_0003;
    localparam logic [63:0] C2 = 64'hC2C2_0000_0000_0004;
    localparam logic [63:0] C3 = 64'hC3C3_0000_0000_0005;
    localparam logic [63:0] C4 = 64'hC4C4_0000_0000_0006;
    localparam logic [63:0] D1 = 64'hD1D1_0000_0000_0007;
    localparam logic [63:0] E1 = 64'hE1E1_0000_0000_0008;
    localparam logic [63:0] F1 = 64'hF1F1_0000_0000_0009;
    localparam logic [63:0] F2 = 64'hF2F2_0000_0000_000A;
    localparam logic [63:0] G1 = 64'h6161_0000_0000_000B;
    localparam logic [63:0] G2 = 64'h6262_0000_0000_000C;
    localparam logic [63:0] G3 = 64'h6363_0000_0000_000D;
    localparam logic [63:0] H1 = 64'h4141_0000_0000_000E;
    localparam logic [63:0] H2 = 64'h4242_0000_0000_000F;
    localparam logic [63:0] H3 = 64'h4343_0000_0000_0010;
    localparam logic [63:0] H4 = 64'h4444_0000_0000_0011;
    localparam logic [63:0] J1 = 64'h5151_0000_0000_0012;
    localparam logic [63:0] DD = 64'hDEAD_BEEF_DEAD_BEEF;

    // in = {valid, last, abort, block_ready}; out = {word_ready, shift_enable, pad_sel, block_valid, block_last}
    typedef struct {
        logic [3:0]   in;
        logic [63:0]  d;
        logic [4:0]   out;
        logic [15:0]  cnt;
        logic         chk_d;
        logic [127:0] exp_d;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in, input logic [63:0] d, input logic [4:0] out,
                                input logic [15:0] cnt, input logic chk_d, input logic [127:0] exp_d);
        vec_t r;
        r.in = in; r.d = d; r.out = out; r.cnt = cnt; r.chk_d = chk_d; r.exp_d = exp_d;
        return r;
    endfunction

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    vec_t vecs[37];

    initial begin
        int hs;
        bit done;
        // two words with the core ready
        vecs[0]  = mk(4'b1001, A,  5'b11000, 16'd0, 1'b0, 128'h0);
        vecs[1]  = mk(4'b1001, B,  5'b11000, 16'd0, 1'b0, 128'h0);
        vecs[2]  = mk(4'b0001, 64'h0, 5'b10010, 16'd0, 1'b1, {A, B});
        vecs[3]  = mk(4'b0100, 64'h0, 5'b10000, 16'd1, 1'b0, 128'h0);
        // backpressure then pass-through of C3
        vecs[4]  = mk(4'b1000, C1, 5'b11000, 16'd1, 1'b0, 128'h0);
        vecs[5]  = mk(4'b1000, C2, 5'b11000, 16'd1, 1'b0, 128'h0);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(4'b1000, C3, 5'b00010, 16'd1, 1'b1, {C1, C2});
        vecs[11] = mk(4'b1001, C3, 5'b11010, 16'd1, 1'b1, {C1, C2});
        // last on the final word of a block: no padding
        vecs[12] = mk(4'b1100, C4, 5'b11000, 16'd2, 1'b0, 128'h0);
        vecs[13] = mk(4'b0001, 64'h0, 5'b10011, 16'd2, 1'b1, {C3, C4});
        // short block: one pad cycle
        vecs[14] = mk(4'b1100, D1, 5'b11000, 16'd3, 1'b0, 128'h0);
        vecs[15] = mk(4'b0000, DD, 5'b01100, 16'd3, 1'b0, 128'h0);
        vecs[16] = mk(4'b0000, 64'h0, 5'b00011, 16'd3, 1'b1, {D1, 64'h0});
        vecs[17] = mk(4'b0001, 64'h0, 5'b10011, 16'd3, 1'b1, {D1, 64'h0});
        // abort after one word, then a clean block
        vecs[18] = mk(4'b1000, E1, 5'b11000, 16'd4, 1'b0, 128'h0);
        vecs[19] = mk(4'b0010, 64'h0, 5'b10000, 16'd4, 1'b0, 128'h0);
        vecs[20] = mk(4'b1000, F1, 5'b11000, 16'd4, 1'b0, 128'h0);
        vecs[21] = mk(4'b1000, F2, 5'b11000, 16'd4, 1'b0, 128'h0);
        vecs[22] = mk(4'b0001, 64'h0, 5'b10010, 16'd4, 1'b1, {F1, F2});
        vecs[23] = mk(4'b0100, 64'h0, 5'b10000, 16'd5, 1'b0, 128'h0);
        // abort wins over a handshake in FULL
        vecs[24] = mk(4'b1000, G1, 5'b11000, 16'd5, 1'b0, 128'h0);
        vecs[25] = mk(4'b1000, G2, 5'b11000, 16'd5, 1'b0, 128'h0);
        vecs[26] = mk(4'b1011, G3, 5'b10010, 16'd5, 1'b1, {G1, G2});
        vecs[27] = mk(4'b0000, 64'h0, 5'b10000, 16'd5, 1'b0, 128'h0);
        // back-to-back blocks with no bubble
        vecs[28] = mk(4'b1001, H1, 5'b11000, 16'd5, 1'b0, 128'h0);
        vecs[29] = mk(4'b1001, H2, 5'b11000, 16'd5, 1'b0, 128'h0);
        vecs[30] = mk(4'b1001, H3, 5'b11010, 16'd5, 1'b1, {H1, H2});
        vecs[31] = mk(4'b1001, H4, 5'b11000, 16'd6, 1'b0, 128'h0);
        vecs[32] = mk(4'b0001, 64'h0, 5'b10010, 16'd6, 1'b1, {H3, H4});
        vecs[33] = mk(4'b0000, 64'h0, 5'b10000, 16'd7, 1'b0, 128'h0);
        // abort during PAD
        vecs[34] = mk(4'b1100, J1, 5'b11000, 16'd7, 1'b0, 128'h0);
        vecs[35] = mk(4'b0010, 64'h0, 5'b00100, 16'd7, 1'b0, 128'h0);
        vecs[36] = mk(4'b0000, 64'h0, 5'b10000, 16'd7, 1'b0, 128'h0);

        rst = 1'b1;
        word_valid = 1'b0; word_last = 1'b0; abort = 1'b0; block_ready = 1'b0; data_in = 64'h0;
        v4 = 1'b0; l4 = 1'b0; ab4 = 1'b0; br4 = 1'b0;
        #2;
        check("reset word_ready", {127'h0, word_ready}, 128'h1);
        check("reset shift_enable", {127'h0, shift_enable}, 128'h0);
        check("reset pad_sel", {127'h0, pad_sel}, 128'h0);
        check("reset block_valid", {127'h0, block_valid}, 128'h0);
        check("reset block_last", {127'h0, block_last}, 128'h0);
        check("reset block_count", {112'h0, block_count}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 37; i++) begin
            {word_valid, word_last, abort, block_ready} = vecs[i].in;
            data_in = vecs[i].d;
            #1;
            check($sformatf("row%0d outputs{wr,se,ps,bv,bl}", i),
                  {123'h0, word_ready, shift_enable, pad_sel, block_valid, block_last},
                  {123'h0, vecs[i].out});
            check($sformatf("row%0d block_count", i), {112'h0, block_count}, {112'h0, vecs[i].cnt});
            if (vecs[i].chk_d)
                check($sformatf("row%0d data_out", i), data_out, vecs[i].exp_d);
            @(posedge clk);
            @(negedge clk);
        end

        // async reset while padding
        word_valid = 1'b1; word_last = 1'b1; abort = 1'b0; block_ready = 1'b0; data_in = J1;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0; word_last = 1'b0;
        #1;
        check("pad before rst {se,ps}", {126'h0, shift_enable, pad_sel}, 128'h3);
        rst = 1'b1;
        #1;
        check("async rst outputs{wr,se,ps,bv,bl}",
              {123'h0, word_ready, shift_enable, pad_sel, block_valid, block_last}, {123'h0, 5'b10000});
        check("async rst block_count", {112'h0, block_count}, 128'h0);
        check("async rst narrow count", {124'h0, cnt4}, 128'h0);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // wrap of a 4-bit block counter after 17 blocks
        v4 = 1'b1; br4 = 1'b1;
        hs = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (bv4) hs++;
            if (hs == 17) begin
                v4 = 1'b0;
                done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("wrap reached 17 handshakes", {127'h0, done}, 128'h1);
        #1;
        check("wrap block_count", {124'h0, cnt4}, 128'h1);
        check("wrap block_valid after", {127'h0, bv4}, 128'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
